// File: rtl/fpu_req_pkg.sv
// Shared definitions for the FPU add/sub requester: controller states,
// rounding-mode codes and operation-select codes.
package fpu_req_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    LAUNCH  = 3'd2,
    WAIT    = 3'd3,
    RELEASE = 3'd4,
    DONE    = 3'd5
  } req_state_e;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_POS_INF = 2'b01;
  localparam logic [1:0] RM_NEG_INF = 2'b10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/fpu_req_watchdog.sv
// Saturating WAIT-cycle counter. Cleared by clr, counts while en is high,
// and flags expired during the cycle whose count reaches LIMIT.
module fpu_req_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_r;

  // Count enabled cycles, holding at LIMIT once reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (en && (cnt_r != CW'(LIMIT))) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // The increment taken in this cycle brings the count to LIMIT.
  assign expired = en && (cnt_r >= CW'(LIMIT - 1));

endmodule

// File: rtl/fpu_addsub_requester.sv
// Initiator-side controller for the FPU add/sub beg_FSM/rst_FSM/ready
// handshake. Accepts one request, launches the FPU, captures its result,
// returns the FPU FSM to idle and offers the result downstream.
// Build option: FPU_REQ_TIMEOUT_EN adds a WAIT watchdog that aborts after
// TIMEOUT_CYC cycles and reports it on out_timeout.
module fpu_addsub_requester
  import fpu_req_pkg::*;
#(
  parameter int W           = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic         in_sub,
  input  logic [1:0]   in_rmode,
  output logic         beg_FSM,
  output logic         rst_FSM,
  output logic [W-1:0] Data_X,
  output logic [W-1:0] Data_Y,
  output logic         add_subt,
  output logic [1:0]   r_mode,
  input  logic         ready,
  input  logic [W-1:0] final_result_ieee,
  input  logic         overflow_flag,
  input  logic         underflow_flag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_ovf,
  output logic         out_unf,
  output logic         out_timeout
);

  req_state_e   state_r, next_state_s;
  logic         accept_s, capture_s, abort_s, expired_s;

  logic         in_ready_r, beg_fsm_r, rst_fsm_r, out_valid_r;
  logic [W-1:0] data_x_r, data_y_r, out_result_r;
  logic         add_subt_r, out_ovf_r, out_unf_r, out_timeout_r;
  logic [1:0]   r_mode_r;

`ifdef FPU_REQ_TIMEOUT_EN
  fpu_req_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_r == LAUNCH),
    .en      (state_r == WAIT),
    .expired (expired_s)
  );
`else
  logic unused_timeout_cfg_s;
  assign unused_timeout_cfg_s = (TIMEOUT_CYC > 0);
  assign expired_s = 1'b0;
`endif

  // Next-state selection and the one-cycle accept/capture/abort strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      // Stay one extra cycle so the rst_FSM pulse is visible before IDLE.
      INIT: begin
        if (rst_fsm_r) next_state_s = IDLE;
        else           next_state_s = INIT;
      end
      IDLE: begin
        if (in_valid) begin
          accept_s     = 1'b1;
          next_state_s = LAUNCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      LAUNCH: next_state_s = WAIT;
      WAIT: begin
        if (ready) begin
          capture_s    = 1'b1;
          next_state_s = RELEASE;
        end else if (expired_s) begin
          abort_s      = 1'b1;
          next_state_s = RELEASE;
        end else begin
          next_state_s = WAIT;
        end
      end
      RELEASE: next_state_s = DONE;
      DONE: begin
        if (out_ready) next_state_s = IDLE;
        else           next_state_s = DONE;
      end
      default: next_state_s = INIT;
    endcase
  end

  // State register and handshake outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= INIT;
      in_ready_r  <= 1'b0;
      beg_fsm_r   <= 1'b0;
      rst_fsm_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s == IDLE);
      beg_fsm_r   <= (next_state_s == LAUNCH);
      rst_fsm_r   <= (next_state_s == INIT) || (next_state_s == RELEASE);
      out_valid_r <= (next_state_s == DONE);
    end
  end

  // Operand registers, loaded on accept and held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_x_r   <= {W{1'b0}};
      data_y_r   <= {W{1'b0}};
      add_subt_r <= 1'b0;
      r_mode_r   <= 2'b00;
    end else if (accept_s) begin
      data_x_r   <= in_x;
      data_y_r   <= in_y;
      add_subt_r <= in_sub;
      r_mode_r   <= in_rmode;
    end else begin
      data_x_r   <= data_x_r;
      data_y_r   <= data_y_r;
      add_subt_r <= add_subt_r;
      r_mode_r   <= r_mode_r;
    end
  end

  // Result registers: FPU result on ready, zeros with timeout on abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_result_r  <= {W{1'b0}};
      out_ovf_r     <= 1'b0;
      out_unf_r     <= 1'b0;
      out_timeout_r <= 1'b0;
    end else if (capture_s) begin
      out_result_r  <= final_result_ieee;
      out_ovf_r     <= overflow_flag;
      out_unf_r     <= underflow_flag;
      out_timeout_r <= 1'b0;
    end else if (abort_s) begin
      out_result_r  <= {W{1'b0}};
      out_ovf_r     <= 1'b0;
      out_unf_r     <= 1'b0;
      out_timeout_r <= 1'b1;
    end else begin
      out_result_r  <= out_result_r;
      out_ovf_r     <= out_ovf_r;
      out_unf_r     <= out_unf_r;
      out_timeout_r <= out_timeout_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign beg_FSM     = beg_fsm_r;
  assign rst_FSM     = rst_fsm_r;
  assign out_valid   = out_valid_r;
  assign Data_X      = data_x_r;
  assign Data_Y      = data_y_r;
  assign add_subt    = add_subt_r;
  assign r_mode      = r_mode_r;
  assign out_result  = out_result_r;
  assign out_ovf     = out_ovf_r;
  assign out_unf     = out_unf_r;
  assign out_timeout = out_timeout_r;

endmodule

// File: tb/tb_fpu_addsub_requester.sv
// Directed, table-driven bench for fpu_addsub_requester with a behavioural
// FPU model of configurable latency.
module tb_fpu_addsub_requester;

  localparam int W    = 32;
  localparam int TCYC = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in_x, in_y;
  logic         in_sub;
  logic [1:0]   in_rmode;
  logic         beg_FSM, rst_FSM;
  logic [W-1:0] Data_X, Data_Y;
  logic         add_subt;
  logic [1:0]   r_mode;
  logic         ready;
  logic [W-1:0] final_result_ieee;
  logic         overflow_flag, underflow_flag;
  logic         out_valid, out_ready;
  logic [W-1:0] out_result;
  logic         out_ovf, out_unf, out_timeout;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // FPU model controls
  int m_lat   = 7;
  bit m_early = 1'b0;
  int m_cnt;
  logic [33:0] m_pend;

  fpu_addsub_requester #(.W(W), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_sub(in_sub), .in_rmode(in_rmode),
    .beg_FSM(beg_FSM), .rst_FSM(rst_FSM),
    .Data_X(Data_X), .Data_Y(Data_Y), .add_subt(add_subt), .r_mode(r_mode),
    .ready(ready), .final_result_ieee(final_result_ieee),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf),
    .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed FPU results: {overflow, underflow, result}
  function automatic logic [33:0] fpu_lookup(input logic [31:0] x, input logic [31:0] y, input logic sub);
    if (!sub && x == 32'h40066666 && y == 32'h40466666)      return {2'b00, 32'h40A66666};
    else if (sub && x == 32'h40466666 && y == 32'h40066666)  return {2'b00, 32'h3F800000};
    else if (!sub && x == 32'h3F800000 && y == 32'h3F800000) return {2'b00, 32'h40000000};
    else if (!sub && x == 32'h7F7FFFFF && y == 32'h7F7FFFFF) return {2'b10, 32'h7F800000};
    else if (sub && x == 32'h00C00000 && y == 32'h00800000)  return {2'b01, 32'h00400000};
    else                                                     return {2'b11, 32'hFFFFFFFF};
  endfunction

  // Behavioural FPU: start on beg_FSM, ready after m_lat edges, idle on rst_FSM.
  always @(posedge clk) begin
    if (rst || rst_FSM) begin
      ready <= 1'b0; m_cnt <= 0;
      final_result_ieee <= 32'h0; overflow_flag <= 1'b0; underflow_flag <= 1'b0;
    end else if (m_early && in_valid && in_ready) begin
      // spurious ready with junk while the requester is in LAUNCH
      ready <= 1'b1; final_result_ieee <= 32'hBAD0BAD0; overflow_flag <= 1'b1;
    end else if (beg_FSM) begin
      ready <= 1'b0; final_result_ieee <= 32'h0; overflow_flag <= 1'b0;
      m_cnt <= m_lat;
      m_pend <= fpu_lookup(Data_X, Data_Y, add_subt);
    end else if (m_cnt == 1) begin
      ready <= 1'b1; m_cnt <= 0;
      {overflow_flag, underflow_flag, final_result_ieee} <= m_pend;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end
  end

  typedef struct {
    logic [31:0] x, y;
    logic        sub;
    logic [1:0]  rm;
    int          lat;
    int          hold;
    bit          hold_valid;
    bit          ordy_early;
    bit          early;
    logic [31:0] exp_res;
    logic        exp_ovf, exp_unf, exp_tmo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int waited, beg_n, rfsm_n, bad, bad2, rdy_cyc, beg_cyc, exp_cyc, val_cyc;
    bit seen_beg, got;
    logic [31:0] res0;
    m_lat = v.lat; m_early = v.early; out_ready = v.ordy_early;
    waited = 0;
    while (!in_ready && waited < 20) begin @(negedge clk); waited++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_x = v.x; in_y = v.y; in_sub = v.sub; in_rmode = v.rm; in_valid = 1'b1;
    beg_n = 0; rfsm_n = 0; bad = 0; rdy_cyc = -1; beg_cyc = -1;
    seen_beg = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (!v.hold_valid) in_valid = 1'b0;
      if (ready && seen_beg && rdy_cyc < 0) rdy_cyc = cyc;
      if (beg_FSM) begin beg_n++; seen_beg = 1; if (beg_cyc < 0) beg_cyc = cyc; end
      if (rst_FSM) rfsm_n++;
      if (in_ready) bad++;
      if (Data_X !== v.x || Data_Y !== v.y || add_subt !== v.sub || r_mode !== v.rm) bad++;
      if (out_valid) got = 1;
    end
    val_cyc = cyc;
    exp_cyc = v.exp_tmo ? beg_cyc + TCYC + 2 : rdy_cyc + 2;
    chk({tag, "_valid_seen"}, got, 1);
    chk({tag, "_latency"}, val_cyc, exp_cyc);
    chk({tag, "_result"}, out_result, v.exp_res);
    chk({tag, "_ovf"}, out_ovf, v.exp_ovf);
    chk({tag, "_unf"}, out_unf, v.exp_unf);
    chk({tag, "_timeout"}, out_timeout, v.exp_tmo);
    chk({tag, "_beg_pulses"}, beg_n, 1);
    chk({tag, "_rst_fsm_pulses"}, rfsm_n, 1);
    chk({tag, "_busy_hold"}, bad, 0);
    res0 = out_result; bad2 = 0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!out_valid || out_result !== res0 || in_ready || beg_FSM || rst_FSM) bad2++;
    end
    if (v.hold > 0) chk({tag, "_backpressure"}, bad2, 0);
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_valid_drop"}, out_valid, 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_back_idle"}, in_ready, 1);
  endtask

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rp, ovs;
    vec_t tv;
    //                x             y             sub   rm     lat hold hv ore early exp_res       ovf   unf   tmo
    vecs[0] = '{32'h40066666, 32'h40466666, 1'b0, 2'b01, 7, 0,  0, 0, 0, 32'h40A66666, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h40466666, 32'h40066666, 1'b1, 2'b00, 3, 0,  0, 0, 0, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h3F800000, 32'h3F800000, 1'b0, 2'b10, 5, 10, 1, 0, 0, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 4, 0,  0, 1, 0, 32'h7F800000, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h00C00000, 32'h00800000, 1'b1, 2'b11, 1, 0,  0, 0, 1, 32'h00400000, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_sub = 1'b0; in_rmode = 2'b00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_rst_fsm", rst_FSM, 0);
    chk("reset_beg_out_valid", {beg_FSM, out_valid, out_timeout}, 0);
    chk("reset_data", {Data_X, Data_Y}, 0);
    chk("reset_result", {out_result, out_ovf, out_unf, add_subt, r_mode}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("init_rst_fsm_high", rst_FSM, 1);
    chk("init_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("init_rst_fsm_low", rst_FSM, 0);
    chk("init_idle", in_ready, 1);

    for (int i = 0; i < 5; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in the third WAIT cycle
    m_lat = 20; m_early = 1'b0;
    in_x = 32'h40066666; in_y = 32'h40466666; in_sub = 1'b0; in_rmode = 2'b01;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (beg_FSM) break;
    end
    chk("midwait_launched", beg_FSM, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midwait_reset_outputs", {out_valid, rst_FSM, in_ready, beg_FSM}, 0);
    chk("midwait_reset_data", Data_X, 0);
    rst = 1'b0;
    rp = 0; ovs = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rst_FSM) rp++;
      if (out_valid) ovs++;
    end
    chk("midwait_init_pulse", rp, 1);
    chk("midwait_no_valid", ovs, 0);
    run_op(vecs[0], "fresh");

`ifdef FPU_REQ_TIMEOUT_EN
    tv = '{32'h12345678, 32'h0BADCAFE, 1'b0, 2'b00, 0, 0, 0, 0, 0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    run_op(tv, "timeout");
    run_op(vecs[1], "after_timeout");
`else
    tv = vecs[0];
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
